pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator for the zarv fetch front end; successor to the fixed 32-bit PC.
//  Generalises XLEN, reset vector and number of prioritised redirect sources.
//  Adds a valid/ready fetch handshake, a debug halt/resume FSM and misaligned-target detection.
//  Sits between the ctrl/ex redirect logic and the instruction-fetch unit.
// PARAMETERS
//  XLEN       32   PC width in bits
//  RESET_VEC  0    PC value after rst or soft_rst_i (XLEN bits, 4-byte aligned)
//  NUM_REDIR  3    redirect sources; index 0 has the highest priority (e.g. 0=trap, 1=jump, 2=debug)
//  HOLD_W     3    width of the pipeline hold code
// PORTS
//  clk           in   1                 clock
//  rst           in   1                 asynchronous reset, active-high
//  soft_rst_i    in   1                 synchronous reset request (JTAG); same effect as rst
//  redir_vld_i   in   NUM_REDIR         per-source redirect request
//  redir_addr_i  in   NUM_REDIR*XLEN    packed targets; source k at [k*XLEN +: XLEN]
//  hold_i        in   HOLD_W            any nonzero value stalls sequential advance
//  instr_c_i     in   1                 current fetch is a 16-bit instruction (used only with PCGEN_RVC_EN)
//  halt_req_i    in   1                 debug halt request
//  resume_i      in   1                 debug resume request
//  pc_ready_i    in   1                 fetch unit accepts pc_o
//  pc_o          out  XLEN              current fetch PC
//  pc_vld_o      out  1                 pc_o is valid for fetch
//  halted_o      out  1                 FSM in HALT
//  misalign_o    out  1                 1-cycle pulse: redirect target was misaligned
// BEHAVIOUR
//  Reset (rst or soft_rst_i): pc_o=RESET_VEC, pc_vld_o=0, halted_o=0, misalign_o=0, state=BOOT.
//   soft_rst_i beats every other input.
//  FSM states:
//   BOOT: pc_vld_o=0; the next clock goes to RUN (first fetch of RESET_VEC one cycle after reset release).
//   RUN:  pc_vld_o=1.
//   HALT: pc_vld_o=0, halted_o=1.
//  Transitions:
//   RUN->HALT on halt_req_i; HALT->RUN on resume_i; halt_req_i is ignored in BOOT.
//   halt_req_i and resume_i together in HALT: resume wins.
//  PC update priority per clock (highest first):
//   1. reset
//   2. redirect: any redir_vld_i bit set; lowest set index selected; loaded in every state, hold ignored.
//      A redirect in BOOT also moves the FSM to RUN.
//   3. sequential advance: RUN && pc_vld_o && pc_ready_i && hold_i==0 -> pc_o += step.
//   4. otherwise pc_o is held.
//  Redirect latency: target appears on pc_o the cycle after redir_vld_i. No combinational path redir->pc_o.
//  Arithmetic: step=4; wraps modulo 2^XLEN (0xFFFF_FFFC+4 -> 0 at XLEN=32).
//  Alignment: target loaded with its low bits forced to 0.
//   misalign_o=1 for one cycle if any dropped bit was 1.
//  Halt with a pending fetch: pc_o is frozen and the handshake is dropped; fetch discards the unaccepted request.
// CONFIGURATION
//  PCGEN_RVC_EN defined:
//   step = instr_c_i ? 2 : 4
//   alignment is 2-byte: only bit0 is cleared/checked
//  PCGEN_RVC_EN undefined:
//   instr_c_i is ignored; step is always 4
//   alignment is 4-byte: bits[1:0] are cleared; misalign_o is raised if either bit is set
// STRUCTURE
//  Shared package pc_pkg:
//   pc_state_e {BOOT, RUN, HALT}
//   PC_STEP_W=4 and PC_STEP_C=2 constants
//   default XLEN
//  One sub-module, pc_redir_arb (combinational):
//   fixed-priority select of redir_vld_i/redir_addr_i
//   produces sel_vld and sel_addr
//  pc_gen holds the FSM, the PC register and the alignment check.
// TESTING
//  1. Release rst, pc_ready_i=1: pc_vld_o=0 for 1 cycle, then pc_o=0,4,8,12 on consecutive cycles.
//  2. hold_i=3'd2 for 3 cycles at pc 0x10 while redir_vld_i[1] targets 0x200:
//     pc_o=0x200 the next cycle, held while hold is active, then 0x204.
//  3. redir_vld_i=3'b110, addr[1]=0x100, addr[2]=0x300 -> pc_o=0x100;
//     then redir_vld_i=3'b111, addr[0]=0x80 -> pc_o=0x80.
//  4. Redirect to 0x1002 without PCGEN_RVC_EN -> pc_o=0x1000, misalign_o one pulse;
//     with PCGEN_RVC_EN -> pc_o=0x1002, no pulse, then +2 when instr_c_i=1.
//  5. halt_req_i at pc 0x40 -> halted_o=1, pc_vld_o=0, pc frozen;
//     redirect to 0x500 in HALT -> pc_o=0x500; resume_i -> RUN fetching 0x500.
//  6. pc_o=0xFFFFFFFC advances to 0; soft_rst_i during HALT -> BOOT, pc_o=RESET_VEC, halted_o=0.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the zarv program-counter generator
//
// Purpose: FSM state type, PC step sizes and the default PC width used by
// pc_gen and pc_redir_arb.
// Ports: none (package).
package pc_pkg;

    // Default PC width when the instantiating level does not override XLEN.
    localparam int unsigned PC_XLEN_DEF = 32;

    // Sequential advance for a 32-bit and a 16-bit (compressed) instruction.
    localparam int unsigned PC_STEP_W = 4;
    localparam int unsigned PC_STEP_C = 2;

    // Fetch front-end run/debug states.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

endpackage : pc_pkg

// File: rtl/pc_redir_arb.sv
// rtl/pc_redir_arb.sv - fixed-priority redirect source selector
//
// Purpose: picks the lowest-indexed asserted redirect request (index 0 wins)
// and forwards its target address. Purely combinational.
// Ports:
//   vld_i       in   NUM_REDIR        per-source redirect request
//   addr_i      in   NUM_REDIR*XLEN   packed targets, source k at [k*XLEN +: XLEN]
//   sel_vld_o   out  1                at least one request is asserted
//   sel_addr_o  out  XLEN             target of the winning source (0 when none)
module pc_redir_arb
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = PC_XLEN_DEF,
    parameter int unsigned NUM_REDIR = 3
) (
    input  logic [NUM_REDIR-1:0]      vld_i,
    input  logic [NUM_REDIR*XLEN-1:0] addr_i,
    output logic                      sel_vld_o,
    output logic [XLEN-1:0]           sel_addr_o
);

    // Scan from the lowest priority upward so the highest-priority hit is
    // the last assignment and therefore the one that sticks.
    always_comb begin
        sel_vld_o  = 1'b0;
        sel_addr_o = '0;
        for (int k = NUM_REDIR - 1; k >= 0; k--) begin
            if (vld_i[k]) begin
                sel_vld_o  = 1'b1;
                sel_addr_o = addr_i[k*XLEN +: XLEN];
            end
        end
    end

endmodule : pc_redir_arb

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator with redirect, fetch handshake and debug halt
//
// Purpose: holds the fetch PC, advances it on accepted fetches, loads
// prioritised redirect targets (aligned, with a misalignment pulse) and runs
// the BOOT/RUN/HALT debug FSM.
// Configuration macro: PCGEN_RVC_EN (compressed-instruction support: 2-byte
// alignment and a step of 2 when instr_c_i is set). Undefined by default.
// Ports:
//   clk           in   1                clock
//   rst           in   1                asynchronous reset, active-high
//   soft_rst_i    in   1                synchronous reset request, overrides all inputs
//   redir_vld_i   in   NUM_REDIR        per-source redirect request (index 0 highest)
//   redir_addr_i  in   NUM_REDIR*XLEN   packed redirect targets
//   hold_i        in   HOLD_W           nonzero stalls sequential advance
//   instr_c_i     in   1                current fetch is 16-bit (PCGEN_RVC_EN only)
//   halt_req_i    in   1                debug halt request
//   resume_i      in   1                debug resume request
//   pc_ready_i    in   1                fetch unit accepts pc_o
//   pc_o          out  XLEN             current fetch PC
//   pc_vld_o      out  1                pc_o valid for fetch
//   halted_o      out  1                FSM in HALT
//   misalign_o    out  1                one-cycle pulse: last redirect target was misaligned
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = PC_XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     NUM_REDIR = 3,
    parameter int unsigned     HOLD_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      soft_rst_i,
    input  logic [NUM_REDIR-1:0]      redir_vld_i,
    input  logic [NUM_REDIR*XLEN-1:0] redir_addr_i,
    input  logic [HOLD_W-1:0]         hold_i,
    input  logic                      instr_c_i,
    input  logic                      halt_req_i,
    input  logic                      resume_i,
    input  logic                      pc_ready_i,
    output logic [XLEN-1:0]           pc_o,
    output logic                      pc_vld_o,
    output logic                      halted_o,
    output logic                      misalign_o
);

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] align_mask;

`ifdef PCGEN_RVC_EN
    assign step       = instr_c_i ? XLEN'(PC_STEP_C) : XLEN'(PC_STEP_W);
    assign align_mask = ~XLEN'(1);
`else
    logic unused_instr_c;
    assign unused_instr_c = instr_c_i;
    assign step           = XLEN'(PC_STEP_W);
    assign align_mask     = ~XLEN'(3);
`endif

    logic            sel_vld;
    logic [XLEN-1:0] sel_addr;

    pc_redir_arb #(
        .XLEN      (XLEN),
        .NUM_REDIR (NUM_REDIR)
    ) u_redir_arb (
        .vld_i      (redir_vld_i),
        .addr_i     (redir_addr_i),
        .sel_vld_o  (sel_vld),
        .sel_addr_o (sel_addr)
    );

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (soft_rst_i) begin
            state_d = BOOT;
            pc_d    = RESET_VEC;
        end else begin
            // BOOT always leaves after one cycle, which also covers a
            // redirect arriving while still booting.
            unique case (state_q)
                BOOT:    state_d = RUN;
                RUN:     state_d = halt_req_i ? HALT : RUN;
                HALT:    state_d = resume_i ? RUN : HALT;
                default: state_d = BOOT;
            endcase

            if (sel_vld) begin
                pc_d       = sel_addr & align_mask;
                misalign_d = |(sel_addr & ~align_mask);
            end else if (state_q == RUN && pc_ready_i && hold_i == '0) begin
                // An accepted fetch advances even on the cycle a halt is
                // requested; only an unaccepted request is frozen in HALT.
                pc_d = pc_q + step;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_vld_o   = (state_q == RUN);
    assign halted_o   = (state_q == HALT);
    assign misalign_o = misalign_q;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen (directed table plus randomized model check)
module tb_pc_gen;

    localparam int XLEN = 32;
    localparam int NR   = 3;
    localparam int HW   = 3;
    localparam logic [31:0] RVEC = 32'h0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            soft_rst_i = 1'b0;
    logic [NR-1:0]   redir_vld_i = '0;
    logic [31:0]     addr [NR];
    logic [NR*XLEN-1:0] redir_addr_i;
    logic [HW-1:0]   hold_i = '0;
    logic            instr_c_i = 1'b0;
    logic            halt_req_i = 1'b0;
    logic            resume_i = 1'b0;
    logic            pc_ready_i = 1'b0;
    logic [31:0]     pc_o;
    logic            pc_vld_o;
    logic            halted_o;
    logic            misalign_o;

    assign redir_addr_i = {addr[2], addr[1], addr[0]};

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN      (XLEN),
        .RESET_VEC (RVEC),
        .NUM_REDIR (NR),
        .HOLD_W    (HW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_i   (soft_rst_i),
        .redir_vld_i  (redir_vld_i),
        .redir_addr_i (redir_addr_i),
        .hold_i       (hold_i),
        .instr_c_i    (instr_c_i),
        .halt_req_i   (halt_req_i),
        .resume_i     (resume_i),
        .pc_ready_i   (pc_ready_i),
        .pc_o         (pc_o),
        .pc_vld_o     (pc_vld_o),
        .halted_o     (halted_o),
        .misalign_o   (misalign_o)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: mode 0=booting, 1=running, 2=halted.
    int              m_mode;
    longint unsigned m_pc;
    bit              m_mis;

`ifdef PCGEN_RVC_EN
    localparam longint unsigned ALIGN = 2;
`else
    localparam longint unsigned ALIGN = 4;
`endif

    task automatic model_reset();
        m_mode = 0;
        m_pc   = RVEC;
        m_mis  = 0;
    endtask

    task automatic model_step();
        int              winner;
        int              next_mode;
        longint unsigned tgt;
        longint unsigned stp;
        if (soft_rst_i) begin
            model_reset();
            return;
        end
        winner = -1;
        for (int k = 0; k < NR; k++)
            if (redir_vld_i[k] && winner < 0) winner = k;
        if (m_mode == 0)      next_mode = 1;
        else if (m_mode == 1) next_mode = halt_req_i ? 2 : 1;
        else                  next_mode = resume_i ? 1 : 2;
`ifdef PCGEN_RVC_EN
        stp = instr_c_i ? 2 : 4;
`else
        stp = 4;
`endif
        m_mis = 0;
        if (winner >= 0) begin
            tgt   = longint'(addr[winner]);
            m_pc  = tgt - (tgt % ALIGN);
            m_mis = (tgt % ALIGN) != 0;
        end else if (m_mode == 1 && pc_ready_i && hold_i == 0) begin
            m_pc = (m_pc + stp) % 64'h1_0000_0000;
        end
        m_mode = next_mode;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".pc"},   pc_o,              32'(m_pc));
        chk({nm, ".vld"},  {31'b0, pc_vld_o}, {31'b0, m_mode == 1});
        chk({nm, ".halt"}, {31'b0, halted_o}, {31'b0, m_mode == 2});
        chk({nm, ".mis"},  {31'b0, misalign_o}, {31'b0, m_mis});
    endtask

    typedef struct {
        bit          srst;
        logic [2:0]  rv;
        logic [31:0] a0, a1, a2;
        logic [2:0]  hold;
        bit          ic, hr, rs, rdy;
        logic [31:0] e_pc;
        bit          e_vld, e_halt, e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit s, input logic [2:0] rv, input logic [31:0] a0, a1, a2,
                       input logic [2:0] h, input bit ic, hr, rs, rdy,
                       input logic [31:0] epc, input bit ev, eh, em);
        vec_t v;
        v.srst = s; v.rv = rv; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.hold = h;
        v.ic = ic; v.hr = hr; v.rs = rs; v.rdy = rdy;
        v.e_pc = epc; v.e_vld = ev; v.e_halt = eh; v.e_mis = em;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        soft_rst_i  = v.srst;
        redir_vld_i = v.rv;
        addr[0] = v.a0; addr[1] = v.a1; addr[2] = v.a2;
        hold_i = v.hold; instr_c_i = v.ic;
        halt_req_i = v.hr; resume_i = v.rs; pc_ready_i = v.rdy;
    endtask

    initial begin
        addr[0] = '0; addr[1] = '0; addr[2] = '0;

        // srst rv a0 a1 a2 hold ic hr rs rdy | pc vld halt mis
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,  1, 0, 0);   // BOOT -> RUN at RESET_VEC
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4,  1, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8,  1, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC,  1, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 1, 0, 0);
        add(0, 3'b010, 0, 32'h200, 0, 3'd2, 0, 0, 0, 1, 32'h200, 1, 0, 0);  // redirect beats hold
        add(0, 3'b000, 0, 0, 0, 3'd2, 0, 0, 0, 1, 32'h200, 1, 0, 0);
        add(0, 3'b000, 0, 0, 0, 3'd2, 0, 0, 0, 1, 32'h200, 1, 0, 0);
        add(0, 3'b000, 0, 0, 0, 3'd0, 0, 0, 0, 1, 32'h204, 1, 0, 0);
        add(0, 3'b110, 0, 32'h100, 32'h300, 0, 0, 0, 0, 1, 32'h100, 1, 0, 0);
        add(0, 3'b111, 32'h80, 32'h100, 32'h300, 0, 0, 0, 0, 1, 32'h80, 1, 0, 0);
`ifdef PCGEN_RVC_EN
        add(0, 3'b010, 0, 32'h1002, 0, 0, 0, 0, 0, 1, 32'h1002, 1, 0, 0);
`else
        add(0, 3'b010, 0, 32'h1002, 0, 0, 0, 0, 0, 1, 32'h1000, 1, 0, 1);
`endif
        add(0, 3'b000, 0, 0, 0, 0, 1, 0, 0, 1, 32'h1004, 1, 0, 0);
        add(0, 3'b001, 32'h40, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 32'h40,  0, 1, 0);   // halt, fetch not accepted
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40,  0, 1, 0);   // frozen in HALT
        add(0, 3'b100, 0, 0, 32'h500, 0, 0, 0, 0, 1, 32'h500, 0, 1, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 1, 1, 1, 32'h500, 1, 0, 0);   // resume beats halt
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h504, 1, 0, 0);
        add(0, 3'b001, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0);     // wrap
        add(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 1, 32'h4, 0, 1, 0);     // accepted fetch advances, then HALT
        add(1, 3'b001, 32'h900, 0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 0, 0); // soft reset beats everything
        add(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 1, 32'h0, 1, 0, 0);     // halt ignored in BOOT
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);     // not ready: hold
        add(0, 3'b000, 0, 0, 0, 3'b100, 0, 0, 0, 1, 32'h0, 1, 0, 0);
        add(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0);
`ifdef PCGEN_RVC_EN
        add(0, 3'b010, 0, 32'h123, 0, 0, 0, 0, 0, 1, 32'h122, 1, 0, 1); // redirect in BOOT
        add(0, 3'b000, 0, 0, 0, 0, 1, 0, 0, 1, 32'h124, 1, 0, 0);
`else
        add(0, 3'b010, 0, 32'h123, 0, 0, 0, 0, 0, 1, 32'h120, 1, 0, 1);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h124, 1, 0, 0);
`endif

        // Reset state while rst is held.
        model_reset();
        @(negedge clk);
        chk("reset", pc_o, RVEC);
        chk("reset.vld",  {31'b0, pc_vld_o},   32'h0);
        chk("reset.halt", {31'b0, halted_o},   32'h0);
        chk("reset.mis",  {31'b0, misalign_o}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            model_step();
            @(negedge clk);
            chk($sformatf("vec%0d.pc", i),   pc_o,                vecs[i].e_pc);
            chk($sformatf("vec%0d.vld", i),  {31'b0, pc_vld_o},   {31'b0, vecs[i].e_vld});
            chk($sformatf("vec%0d.halt", i), {31'b0, halted_o},   {31'b0, vecs[i].e_halt});
            chk($sformatf("vec%0d.mis", i),  {31'b0, misalign_o}, {31'b0, vecs[i].e_mis});
            chk_model($sformatf("vec%0d.model", i));
        end

        // Asynchronous reset between clock edges takes effect immediately.
        drive('{0, 3'b001, 32'h7770, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        model_step();
        @(negedge clk);
        chk_model("pre_async");
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_model("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against the model.
        for (int c = 0; c < 3000; c++) begin
            soft_rst_i  = ($urandom_range(0, 99) < 2);
            redir_vld_i = ($urandom_range(0, 99) < 15) ? 3'($urandom_range(1, 7)) : 3'b000;
            for (int k = 0; k < NR; k++)
                addr[k] = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
            hold_i     = ($urandom_range(0, 99) < 20) ? 3'($urandom_range(1, 7)) : 3'd0;
            instr_c_i  = 1'($urandom_range(0, 1));
            halt_req_i = ($urandom_range(0, 99) < 6);
            resume_i   = ($urandom_range(0, 99) < 15);
            pc_ready_i = ($urandom_range(0, 99) < 75);
            model_step();
            @(negedge clk);
            chk_model($sformatf("rand%0d", c));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pc_gen
